// File: rtl/bit_population_counter_pipe_pkg.sv
// Shared types and elaboration-time helpers for the pipelined population counter.
// Sizing functions are used by both the RTL and the bench so they agree on widths.
package bpc_pkg;

  typedef enum logic {BPC_ONES = 1'b0, BPC_ZEROS = 1'b1} bpc_mode_t;

  function automatic int bpc_cnt_w(int w);
    return $clog2(w + 1);
  endfunction

  function automatic int bpc_ceil_div(int a, int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int bpc_levels(int num_leaves);
    return (num_leaves <= 1) ? 0 : $clog2(num_leaves);
  endfunction

  // Node count at a tree level; an odd node at a level passes up unpaired.
  function automatic int bpc_nodes(int num_leaves, int lvl);
    int n;
    n = num_leaves;
    for (int i = 0; i < lvl; i++) begin
      n = (n + 1) / 2;
    end
    return n;
  endfunction

  // Count width at a level: one extra bit per level, never wider than the final result.
  function automatic int bpc_lvl_w(int leaf_w, int width, int lvl);
    int w;
    w = bpc_cnt_w(leaf_w) + lvl;
    return (w > bpc_cnt_w(width)) ? bpc_cnt_w(width) : w;
  endfunction

endpackage

// File: rtl/bit_population_counter_pipe_if.sv
// Stream interface for the population counter: word-in and count-out handshakes.
// The slave modport is the counter; the master modport is the source/sink around it.
interface bit_population_counter_pipe_if #(
  parameter int WIDTH = 32
);
  import bpc_pkg::*;

  localparam int CNT_W = bpc_cnt_w(WIDTH);

  logic [WIDTH-1:0] data_i;
  logic             mode_i;
  logic             data_val_i;
  logic             data_rdy_o;
  logic [CNT_W-1:0] data_o;
  logic             data_mode_o;
  logic             data_val_o;
  logic             data_rdy_i;

  modport master (
    output data_i, mode_i, data_val_i, data_rdy_i,
    input  data_rdy_o, data_o, data_mode_o, data_val_o
  );

  modport slave (
    input  data_i, mode_i, data_val_i, data_rdy_i,
    output data_rdy_o, data_o, data_mode_o, data_val_o
  );

endinterface

// File: rtl/bit_population_counter_pipe_leaf.sv
// Combinational popcount of one LEAF_W-bit slice of the padded input word.
module bpc_leaf
  import bpc_pkg::*;
#(
  parameter int LEAF_W = 4
) (
  input  logic [LEAF_W-1:0]            bits_i,
  output logic [bpc_cnt_w(LEAF_W)-1:0] cnt_o
);

  localparam int CW = bpc_cnt_w(LEAF_W);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < LEAF_W; i++) begin
      cnt_o = cnt_o + CW'(bits_i[i]);
    end
  end

endmodule

// File: rtl/bit_population_counter_pipe.sv
// Pipelined popcount: registered leaf counts followed by a registered pairwise adder tree.
// One global advance enable freezes every stage while the output is stalled.
module bit_population_counter_pipe
  import bpc_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int LEAF_W = 4
) (
  input  logic                          clk_i,
  input  logic                          srst_i,
  bit_population_counter_pipe_if.slave  bus
);

  localparam int NUM_LEAVES = bpc_ceil_div(WIDTH, LEAF_W);
  localparam int LEVELS     = bpc_levels(NUM_LEAVES);
  localparam int PAD_W      = NUM_LEAVES * LEAF_W;

  logic             adv;
  logic [PAD_W-1:0] word_pad;

  // Bubbles enter as an all-zero word so every invalid stage carries zero counts and mode.
  always_comb begin
    word_pad = '0;
    if (bus.data_val_i) begin
      word_pad[WIDTH-1:0] = (bus.mode_i == BPC_ZEROS) ? ~bus.data_i : bus.data_i;
    end
  end

  for (genvar l = 0; l <= LEVELS; l++) begin : gen_lvl
    localparam int N = bpc_nodes(NUM_LEAVES, l);
    localparam int W = bpc_lvl_w(LEAF_W, WIDTH, l);

    logic [N-1:0][W-1:0] sum;
    logic [N-1:0][W-1:0] cnt_d;
    logic [N-1:0][W-1:0] cnt_q;
    logic                val_in;
    logic                mode_in;
    logic                val_d;
    logic                val_q;
    logic                mode_d;
    logic                mode_q;

    if (l == 0) begin : g_leaf
      for (genvar k = 0; k < N; k++) begin : g_cnt
        bpc_leaf #(.LEAF_W(LEAF_W)) u_leaf (
          .bits_i (word_pad[k*LEAF_W +: LEAF_W]),
          .cnt_o  (sum[k])
        );
      end
      assign val_in  = bus.data_val_i;
      assign mode_in = bus.data_val_i & bus.mode_i;
    end else begin : g_add
      localparam int NP = bpc_nodes(NUM_LEAVES, l - 1);
      for (genvar j = 0; j < N; j++) begin : g_node
        if (2*j + 1 < NP) begin : g_pair
          assign sum[j] = W'(gen_lvl[l-1].cnt_q[2*j]) + W'(gen_lvl[l-1].cnt_q[2*j+1]);
        end else begin : g_pass
          assign sum[j] = W'(gen_lvl[l-1].cnt_q[2*j]);
        end
      end
      assign val_in  = gen_lvl[l-1].val_q;
      assign mode_in = gen_lvl[l-1].mode_q;
    end

    always_comb begin
      cnt_d  = cnt_q;
      val_d  = val_q;
      mode_d = mode_q;
      if (adv) begin
        cnt_d  = sum;
        val_d  = val_in;
        mode_d = mode_in;
      end
    end

    always_ff @(posedge clk_i) begin
      if (srst_i) begin
        cnt_q  <= '0;
        val_q  <= 1'b0;
        mode_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        val_q  <= val_d;
        mode_q <= mode_d;
      end
    end
  end

  assign bus.data_val_o  = gen_lvl[LEVELS].val_q;
  assign bus.data_o      = gen_lvl[LEVELS].cnt_q[0];
  assign bus.data_mode_o = gen_lvl[LEVELS].mode_q;

  assign adv            = ~(bus.data_val_o & ~bus.data_rdy_i);
  assign bus.data_rdy_o = adv;

endmodule
